id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined MIPS core. It sits directly downstream of the main control decoder. It registers that decoder's control bundle together with the ID-stage operands into the EX stage. It also owns load-use and branch-operand hazard detection, and drives the `stall` signal back into the decoder, the PC and IF/ID. A stall or an external flush makes the stage insert a bubble: all EX control bits are zero.

---
 rtl/id_ex_stage.sv | 176 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the pipelined MIPS core.
// Registers the decoder's control bundle and the ID-stage operands into EX.
// Detects load-use and branch-operand hazards and drives the stall signal
// back to the decoder, the PC and IF/ID. A stall or flush inserts a bubble
// (all EX control bits zero, ex_wreg zero).
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   id_* control      decoder control bundle (regdst..jal, aluop)
//   id_* data         pc4, rd1, rd2, imm (DW), rs/rt/rd (5), funct (6)
//   flush             kill the ID instruction (taken branch/jump)
//   stall             combinational hazard stall
//   ex_*              registered control/data, ex_wreg = destination register
//   bubble_cnt        saturating count of stall-inserted bubbles
module id_ex_stage #(
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_regdst,
  input  logic            id_alusrc,
  input  logic            id_memtoreg,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic            id_jal,
  input  logic [1:0]      id_aluop,
  input  logic [DW-1:0]   id_pc4,
  input  logic [DW-1:0]   id_rd1,
  input  logic [DW-1:0]   id_rd2,
  input  logic [DW-1:0]   id_imm,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [5:0]      id_funct,
  input  logic            flush,
  output logic            stall,
  output logic            ex_regdst,
  output logic            ex_alusrc,
  output logic            ex_memtoreg,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_jal,
  output logic [1:0]      ex_aluop,
  output logic [DW-1:0]   ex_pc4,
  output logic [DW-1:0]   ex_rd1,
  output logic [DW-1:0]   ex_rd2,
  output logic [DW-1:0]   ex_imm,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [5:0]      ex_funct,
  output logic [4:0]      ex_wreg,
  output logic [CNTW-1:0] bubble_cnt
);

  typedef enum logic {RUN, STALL2} state_t;

  state_t     state, state_next;
  logic       wreg_hit, lu, br, alu_br, bubble;
  logic [4:0] wreg_sel;

  // Hazard terms, all against the registered EX instruction; $0 never hazards.
  always_comb begin
    wreg_hit = (ex_wreg != 5'd0) && ((ex_wreg == id_rs) || (ex_wreg == id_rt));
    lu       = ex_memread && wreg_hit;
    br       = id_branch && !id_jump;
    alu_br   = br && ex_regwrite && !ex_memread && wreg_hit;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next-state logic: a load feeding a BEQ needs a second stall cycle,
  // by which time the load has reached MEM.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN:     if (lu && br) state_next = STALL2;
        STALL2:  state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    stall = 1'b0;
    if (!rst && !flush)
      stall = ((state == RUN) && (lu || alu_br)) || (state == STALL2);
  end

  // Destination select; an X select falls through to id_rt so a defined
  // id_rt always yields a defined ex_wreg.
  always_comb begin
    if (id_jal)         wreg_sel = 5'd31;
    else if (id_regdst) wreg_sel = id_rd;
    else                wreg_sel = id_rt;
  end

  always_comb bubble = flush || stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_regdst   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_jump     <= 1'b0;
      ex_jal      <= 1'b0;
      ex_aluop    <= '0;
      ex_wreg     <= '0;
      ex_pc4      <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_funct    <= '0;
    end else begin
      if (bubble) begin
        ex_regdst   <= 1'b0;
        ex_alusrc   <= 1'b0;
        ex_memtoreg <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_branch   <= 1'b0;
        ex_jump     <= 1'b0;
        ex_jal      <= 1'b0;
        ex_aluop    <= '0;
        ex_wreg     <= '0;
      end else begin
        ex_regdst   <= id_regdst;
        ex_alusrc   <= id_alusrc;
        ex_memtoreg <= id_memtoreg;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
        ex_memwrite <= id_memwrite;
        ex_branch   <= id_branch;
        ex_jump     <= id_jump;
        ex_jal      <= id_jal;
        ex_aluop    <= id_aluop;
        ex_wreg     <= wreg_sel;
      end
      // Data fields capture unconditionally; they are ignored behind a bubble.
      ex_pc4   <= id_pc4;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_funct <= id_funct;
    end
  end

  // Flush bubbles are excluded because stall is already gated by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            bubble_cnt <= '0;
    else if (stall && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNTW'(1);
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int unsigned DW   = 32;
  localparam int unsigned CNTW = 4;

  logic clk = 1'b0;
  logic rst;
  logic id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread;
  logic id_memwrite, id_branch, id_jump, id_jal;
  logic [1:0] id_aluop;
  logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [5:0] id_funct;
  logic flush, stall;
  logic ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
  logic ex_memwrite, ex_branch, ex_jump, ex_jal;
  logic [1:0] ex_aluop;
  logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_wreg;
  logic [5:0] ex_funct;
  logic [CNTW-1:0] bubble_cnt;

  id_ex_stage #(.DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .id_regdst(id_regdst), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_jump(id_jump), .id_jal(id_jal), .id_aluop(id_aluop),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .flush(flush), .stall(stall),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jal(ex_jal), .ex_aluop(ex_aluop),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_funct(ex_funct), .ex_wreg(ex_wreg),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Control encodings {regdst,alusrc,memtoreg,regwrite,memread,memwrite,branch,jump,jal}
  localparam logic [8:0] C_RTYPE = 9'b1_0_0_1_0_0_0_0_0;
  localparam logic [8:0] C_LW    = 9'b0_1_1_1_1_0_0_0_0;
  localparam logic [8:0] C_BEQ   = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] C_JAL   = 9'b0_0_0_1_0_0_0_1_1;
  localparam logic [8:0] C_NOP   = 9'b0;

  typedef struct {
    logic [10:0]     ctrl;
    logic [4:0]      wreg;
    logic [DW-1:0]   rd1;
    logic [5:0]      funct;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model of the EX-side state
  logic            m_memread, m_regwrite, m_stall2;
  logic [4:0]      m_wreg;
  logic [CNTW-1:0] m_cnt;
  logic [DW-1:0]   pc_seq = 32'h0040_0000;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_memread = 1'b0; m_regwrite = 1'b0; m_stall2 = 1'b0;
    m_wreg = '0; m_cnt = '0;
    q.delete();
  endtask

  task automatic load_id(input logic [8:0] c, input logic [1:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [DW-1:0] rd1);
    {id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread,
     id_memwrite, id_branch, id_jump, id_jal} = c;
    id_aluop = op;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rd1 = rd1;
    id_rd2 = rd1 ^ 32'h5a5a_0000;
    id_imm = {27'd0, rd};
    id_funct = {1'b1, rd};
    pc_seq = pc_seq + 32'd4;
    id_pc4 = pc_seq;
  endtask

  // Entered at a falling edge with ID inputs already driven; returns at the next falling edge.
  task automatic step(output logic st);
    exp_t e, g;
    logic dep, load_use, beq, alu_beq, kill;
    #1;
    dep      = (m_wreg != 5'd0) && ((id_rs == m_wreg) || (id_rt == m_wreg));
    load_use = m_memread && dep;
    beq      = id_branch && !id_jump;
    alu_beq  = beq && m_regwrite && !m_memread && dep;
    st       = !flush && (m_stall2 || load_use || alu_beq);
    chk("stall", stall, st);
    kill = flush || st;
    e.ctrl  = kill ? 11'd0 : {id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread,
                              id_memwrite, id_branch, id_jump, id_jal, id_aluop};
    e.wreg  = kill ? 5'd0 : (id_jal ? 5'd31 : (id_regdst ? id_rd : id_rt));
    e.rd1   = id_rd1;
    e.funct = id_funct;
    e.cnt   = (st && m_cnt != {CNTW{1'b1}}) ? m_cnt + 1'b1 : m_cnt;
    q.push_back(e);
    m_stall2   = !flush && !m_stall2 && load_use && beq;
    m_memread  = kill ? 1'b0 : id_memread;
    m_regwrite = kill ? 1'b0 : id_regwrite;
    m_wreg     = e.wreg;
    m_cnt      = e.cnt;
    @(posedge clk);
    #1;
    chk("queue_nonempty", 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      g = q.pop_front();
      chk("ex_ctrl", {ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                      ex_memwrite, ex_branch, ex_jump, ex_jal, ex_aluop}, g.ctrl);
      chk("ex_wreg", ex_wreg, g.wreg);
      chk("ex_rd1", ex_rd1, g.rd1);
      chk("ex_funct", ex_funct, g.funct);
      chk("bubble_cnt", bubble_cnt, g.cnt);
    end
    @(negedge clk);
  endtask

  // Hold the instruction in ID until it enters EX; returns the number of stall cycles.
  task automatic issue(input logic [8:0] c, input logic [1:0] op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [DW-1:0] rd1, output int unsigned nst);
    logic st;
    load_id(c, op, rs, rt, rd, rd1);
    nst = 0;
    st = 1'b1;
    for (int unsigned i = 0; i < 6 && st; i++) begin
      step(st);
      if (st) nst++;
    end
    if (st) chk("issue_bound", 64'(st), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic st;

    // Reset with every input at 1
    rst = 1'b1; flush = 1'b1;
    {id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread,
     id_memwrite, id_branch, id_jump, id_jal} = '1;
    id_aluop = '1; id_pc4 = '1; id_rd1 = '1; id_rd2 = '1; id_imm = '1;
    id_rs = '1; id_rt = '1; id_rd = '1; id_funct = '1;
    #2;
    chk("rst_stall", stall, 0);
    @(posedge clk); #1;
    chk("rst_ctrl", {ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                     ex_memwrite, ex_branch, ex_jump, ex_jal, ex_aluop}, 0);
    chk("rst_wreg", ex_wreg, 0);
    chk("rst_data", {ex_pc4, ex_rd1}, 0);
    chk("rst_data2", {ex_rd2, ex_imm}, 0);
    chk("rst_fields", {ex_rs, ex_rt, ex_funct}, 0);
    chk("rst_cnt", bubble_cnt, 0);
    chk("rst_stall2", stall, 0);
    @(negedge clk);
    flush = 1'b0;
    load_id(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0, '0);
    rst = 1'b0;
    model_reset();

    // R-type rd=5, then independent instructions
    issue(C_RTYPE, 2'b10, 5'd1, 5'd2, 5'd5, 32'h11, n);
    chk("rtype_nstall", n, 0);
    chk("rtype_wreg", ex_wreg, 5);
    chk("rtype_rd1", ex_rd1, 32'h11);
    issue(C_RTYPE, 2'b10, 5'd3, 5'd4, 5'd6, 32'h22, n);
    chk("indep1_nstall", n, 0);
    issue(C_RTYPE, 2'b10, 5'd7, 5'd1, 5'd2, 32'h33, n);
    chk("indep2_nstall", n, 0);

    // Load-use: one bubble
    issue(C_LW, 2'b00, 5'd1, 5'd8, 5'd0, 32'h100, n);
    issue(C_RTYPE, 2'b10, 5'd8, 5'd2, 5'd9, 32'h44, n);
    chk("lu_nstall", n, 1);
    chk("lu_cnt", bubble_cnt, 1);
    chk("lu_add_in_ex", {ex_regwrite, ex_wreg}, {1'b1, 5'd9});

    // Load-to-BEQ: two stall cycles
    issue(C_LW, 2'b00, 5'd1, 5'd8, 5'd0, 32'h200, n);
    issue(C_BEQ, 2'b01, 5'd8, 5'd3, 5'd0, 32'h55, n);
    chk("lbeq_nstall", n, 2);
    chk("lbeq_cnt", bubble_cnt, 3);

    // ALU-to-BEQ: one stall cycle
    issue(C_RTYPE, 2'b10, 5'd1, 5'd2, 5'd12, 32'h66, n);
    issue(C_BEQ, 2'b01, 5'd4, 5'd12, 5'd0, 32'h77, n);
    chk("abeq_nstall", n, 1);
    chk("abeq_cnt", bubble_cnt, 4);

    // Load writing $0 never hazards
    issue(C_LW, 2'b00, 5'd1, 5'd0, 5'd0, 32'h300, n);
    issue(C_RTYPE, 2'b10, 5'd0, 5'd0, 5'd10, 32'h88, n);
    chk("r0_nstall", n, 0);
    chk("r0_cnt", bubble_cnt, 4);

    // Flush in the second cycle of a load-to-BEQ stall
    issue(C_LW, 2'b00, 5'd1, 5'd8, 5'd0, 32'h400, n);
    load_id(C_BEQ, 2'b01, 5'd8, 5'd3, 5'd0, 32'h99);
    step(st);
    chk("fl_first_stall", st, 1);
    flush = 1'b1;
    step(st);
    chk("fl_stall", st, 0);
    chk("fl_branch", ex_branch, 0);
    chk("fl_cnt", bubble_cnt, 5);
    flush = 1'b0;
    load_id(C_BEQ, 2'b01, 5'd8, 5'd3, 5'd0, 32'haa);
    step(st);
    chk("fl_run_after", st, 0);

    // JAL
    issue(C_JAL, 2'b00, 5'd0, 5'd0, 5'd0, 32'hbb, n);
    chk("jal_wreg", ex_wreg, 31);
    chk("jal_bit", ex_jal, 1);

    // Reset asserted while in STALL2
    issue(C_LW, 2'b00, 5'd1, 5'd8, 5'd0, 32'h500, n);
    load_id(C_BEQ, 2'b01, 5'd8, 5'd3, 5'd0, 32'hcc);
    step(st);
    chk("rs2_first_stall", st, 1);
    rst = 1'b1;
    #1;
    chk("rs2_stall_in_rst", stall, 0);
    chk("rs2_cnt_in_rst", bubble_cnt, 0);
    chk("rs2_wreg_in_rst", ex_wreg, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(st);
    chk("rs2_no_stall", st, 0);

    // Saturation with CNTW=4: 18 load-use bubbles hold at 15
    issue(C_RTYPE, 2'b10, 5'd1, 5'd2, 5'd3, 32'h1, n);
    for (int unsigned i = 0; i < 18; i++) begin
      issue(C_LW, 2'b00, 5'd1, 5'd8, 5'd0, 32'h600 + i, n);
      issue(C_RTYPE, 2'b10, 5'd8, 5'd2, 5'd9, 32'h700 + i, n);
    end
    chk("sat_cnt", bubble_cnt, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
